// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state encoding, default preamble and helpers for the 1010 serial transmitter
package seq_tx_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_PRE  = S_PRE,
        ST_DATA = S_DATA,
        ST_GAP  = S_GAP
    } state_t;

    localparam logic [3:0] DEF_PRE_PATTERN = 4'b1010;

    // Largest segment length, used to size the shared bit counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_1010_tx_if.sv
// rtl/seq_1010_tx_if.sv - word handshake and serial line bundle of the 1010 transmitter
// Ports (via modports):
//   master : drives in_data/in_valid/abort, observes in_ready/out/out_en/busy/done
//   slave  : the transmitter side of the same signals
interface seq_1010_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             out;
    logic             out_en;
    logic             busy;
    logic             done;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, out, out_en, busy, done
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, out, out_en, busy, done
    );
endinterface

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-load, MSB-first shift register
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   load      : capture din (wins over shift)
//   shift     : move contents one place toward the MSB, zero fill
//   din       : parallel load value
//   msb       : current serial bit
module piso_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         msb
);

    logic [N-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            // Plain shift keeps the N=1 case legal (no q[N-2:0] slice).
            q <= q << 1;
        end
    end

    assign msb = q[N-1];

endmodule

// File: rtl/seq_1010_tx.sv
// rtl/seq_1010_tx.sv - frames parallel words as preamble + MSB-first data + idle gap on a serial line
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-low reset
//   bus  : seq_1010_tx_if.slave - in_data/in_valid/in_ready handshake, abort,
//          serial out, out_en (preamble or data bit), busy, done (last data bit)
module seq_1010_tx
    import seq_tx_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter int                 PRE_LEN     = 4,
    parameter logic [PRE_LEN-1:0] PRE_PATTERN = PRE_LEN'(DEF_PRE_PATTERN),
    parameter int                 GAP_LEN     = 2
) (
    input  logic          clk,
    input  logic          rst,
    seq_1010_tx_if.slave  bus
);

    localparam int CW = $clog2(max3(WIDTH, PRE_LEN, GAP_LEN) + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          last;
    logic          pre_bit;
    logic          data_bit;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == CW'(1));

    // Both shifters are loaded on the accept edge so in_data may change afterwards.
    piso_shift #(.N(PRE_LEN)) u_pre (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == ST_PRE),
        .din   (PRE_PATTERN),
        .msb   (pre_bit)
    );

    piso_shift #(.N(WIDTH)) u_data (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == ST_DATA),
        .din   (bus.in_data),
        .msb   (data_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter is loaded with the segment length on entry and the segment is
    // left when it reads 1, so it never decrements past 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_PRE;
                    cnt_nxt   = CW'(PRE_LEN);
                end
            end
            ST_PRE: begin
                if (last) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = CW'(WIDTH);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_DATA: begin
                if (last) begin
                    if (GAP_LEN > 0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = CW'(GAP_LEN);
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (last) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (bus.abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end
    end

    // The line is a state-selected mux of flop outputs, so it carries no
    // combinational path from any input.
    assign bus.out      = (state == ST_PRE)  ? pre_bit  :
                          (state == ST_DATA) ? data_bit : 1'b0;
    assign bus.out_en   = (state == ST_PRE) || (state == ST_DATA);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.in_ready = (state == ST_IDLE) && !bus.abort;
    // An abort raised while the last data bit is on the line cancels the pulse.
    assign bus.done     = (state == ST_DATA) && last && !bus.abort;

endmodule

// File: tb/tb_seq_1010_tx.sv
// tb/tb_seq_1010_tx.sv - directed self-checking bench for seq_1010_tx
module tb_seq_1010_tx;

    logic clk = 1'b0;
    logic rst;
    int   npass  = 0;
    int   ntotal = 0;

    always #5 clk = ~clk;

    seq_1010_tx_if #(.WIDTH(8)) ia ();
    seq_1010_tx_if #(.WIDTH(1)) ib ();

    seq_1010_tx #(.WIDTH(8), .PRE_LEN(4), .PRE_PATTERN(4'b1010), .GAP_LEN(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    seq_1010_tx #(.WIDTH(1), .PRE_LEN(4), .PRE_PATTERN(4'b1010), .GAP_LEN(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    // Overlapping Mealy 1010 detector fed from dut_a's line.
    logic [2:0] det_hist;
    logic       det_pulse;
    always_ff @(posedge clk) begin
        det_hist <= ia.out_en ? {det_hist[1:0], ia.out} : 3'b000;
    end
    assign det_pulse = ia.out_en && (det_hist == 3'b101) && !ia.out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntotal++;
        assert (obs === exp_v) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    initial begin
        logic [11:0] fa;
        logic [11:0] f1;
        logic [11:0] f2;
        logic [4:0]  fb;
        int          det_cnt;

        rst         = 1'b0;
        ia.in_data  = '0;
        ia.in_valid = 1'b0;
        ia.abort    = 1'b0;
        ib.in_data  = '0;
        ib.in_valid = 1'b0;
        ib.abort    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out",      ia.out,      1'b0);
        chk("rst_out_en",   ia.out_en,   1'b0);
        chk("rst_busy",     ia.busy,     1'b0);
        chk("rst_done",     ia.done,     1'b0);
        chk("rst_in_ready", ia.in_ready, 1'b1);
        rst = 1'b1;
        tick();

        // Single frame 8'hA5
        fa          = {4'b1010, 8'hA5};
        ia.in_data  = 8'hA5;
        ia.in_valid = 1'b1;
        #1;
        chk("a5_ready", ia.in_ready, 1'b1);
        tick();
        ia.in_valid = 1'b0;
        ia.in_data  = 8'h00;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("a5_out[%0d]", i),  ia.out,    fa[11-i]);
            chk($sformatf("a5_en[%0d]", i),   ia.out_en, 1'b1);
            chk($sformatf("a5_done[%0d]", i), ia.done,   (i == 11) ? 1'b1 : 1'b0);
            tick();
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("a5_gap_en[%0d]", g),    ia.out_en,   1'b0);
            chk($sformatf("a5_gap_busy[%0d]", g),  ia.busy,     1'b1);
            chk($sformatf("a5_gap_ready[%0d]", g), ia.in_ready, 1'b0);
            tick();
        end
        chk("a5_idle_busy",  ia.busy,     1'b0);
        chk("a5_idle_ready", ia.in_ready, 1'b1);

        // Reset asserted on the 3rd data bit
        ia.in_data  = 8'hFF;
        ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_en_before",   ia.out_en, 1'b1);
        chk("mid_busy_before", ia.busy,   1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out",  ia.out,    1'b0);
        chk("mid_rst_en",   ia.out_en, 1'b0);
        chk("mid_rst_busy", ia.busy,   1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel_ready", ia.in_ready, 1'b1);
        chk("mid_rel_busy",  ia.busy,     1'b0);

        // Back-to-back 8'h0F then 8'hF0 with in_valid held high
        f1          = {4'b1010, 8'h0F};
        f2          = {4'b1010, 8'hF0};
        ia.in_data  = 8'h0F;
        ia.in_valid = 1'b1;
        tick();
        ia.in_data  = 8'hF0;
        for (int c = 1; c <= 27; c++) begin
            if (c <= 12) begin
                chk($sformatf("b2b_out[%0d]", c),  ia.out,    f1[12-c]);
                chk($sformatf("b2b_en[%0d]", c),   ia.out_en, 1'b1);
                chk($sformatf("b2b_done[%0d]", c), ia.done,   (c == 12) ? 1'b1 : 1'b0);
            end else if (c <= 14) begin
                chk($sformatf("b2b_gap_en[%0d]", c),   ia.out_en, 1'b0);
                chk($sformatf("b2b_gap_busy[%0d]", c), ia.busy,   1'b1);
            end else if (c == 15) begin
                chk("b2b_idle_busy",  ia.busy,     1'b0);
                chk("b2b_idle_ready", ia.in_ready, 1'b1);
            end else begin
                chk($sformatf("b2b_out[%0d]", c),  ia.out,    f2[27-c]);
                chk($sformatf("b2b_en[%0d]", c),   ia.out_en, 1'b1);
                chk($sformatf("b2b_done[%0d]", c), ia.done,   (c == 27) ? 1'b1 : 1'b0);
            end
            if (c == 27) ia.in_valid = 1'b0;
            else tick();
        end
        tick();
        tick();
        tick();
        chk("b2b_end_busy", ia.busy, 1'b0);

        // Abort on the last data bit of 8'hFF
        ia.in_data  = 8'hFF;
        ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        for (int i = 1; i < 12; i++) tick();
        chk("ab_last_en",  ia.out_en, 1'b1);
        chk("ab_last_out", ia.out,    1'b1);
        ia.abort = 1'b1;
        #1;
        chk("ab_no_done",  ia.done,     1'b0);
        chk("ab_no_ready", ia.in_ready, 1'b0);
        tick();
        ia.abort    = 1'b0;
        ia.in_valid = 1'b1;
        ia.in_data  = 8'h81;
        #1;
        chk("ab_idle_busy",  ia.busy,     1'b0);
        chk("ab_idle_en",    ia.out_en,   1'b0);
        chk("ab_idle_done",  ia.done,     1'b0);
        chk("ab_idle_ready", ia.in_ready, 1'b1);
        tick();
        ia.in_valid = 1'b0;
        chk("ab_new_busy", ia.busy,   1'b1);
        chk("ab_new_en",   ia.out_en, 1'b1);
        chk("ab_new_out",  ia.out,    1'b1);
        ia.abort = 1'b1;
        tick();
        chk("ab_pre_busy", ia.busy, 1'b0);
        // abort in IDLE blocks an accept
        ia.in_valid = 1'b1;
        #1;
        chk("ab_idle_blk_ready", ia.in_ready, 1'b0);
        tick();
        ia.abort    = 1'b0;
        ia.in_valid = 1'b0;
        chk("ab_idle_blk_busy", ia.busy, 1'b0);
        tick();

        // WIDTH=1, GAP_LEN=0 instance
        fb          = 5'b10101;
        ib.in_data  = 1'b1;
        ib.in_valid = 1'b1;
        tick();
        ib.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w1_out[%0d]", i),  ib.out,    fb[4-i]);
            chk($sformatf("w1_en[%0d]", i),   ib.out_en, 1'b1);
            chk($sformatf("w1_done[%0d]", i), ib.done,   (i == 4) ? 1'b1 : 1'b0);
            tick();
        end
        chk("w1_after_ready", ib.in_ready, 1'b1);
        chk("w1_after_busy",  ib.busy,     1'b0);

        // Loopback into the 1010 detector with all-zero data
        det_cnt     = 0;
        ia.in_data  = 8'h00;
        ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("det_pulse[%0d]", c), det_pulse, (c == 4) ? 1'b1 : 1'b0);
            if (det_pulse) det_cnt++;
            tick();
        end
        chk("det_count", det_cnt, 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
